// File: rtl/multi_channel_clock_divider.sv
// N-channel programmable 50%-duty clock divider with a single-slot valid/ready reconfiguration port.
// Optional per-channel terminal-count strobe output enabled by defining DIV_TICK_OUT_EN.
module multi_channel_clock_divider #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 27,
  parameter int DEFAULT_HALF = 50_000_000,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_100Mhz,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_half,
  output logic [CHANNELS-1:0] clk_out
`ifdef DIV_TICK_OUT_EN
  ,
  output logic [CHANNELS-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0]    cnt  [CHANNELS];
  logic [CNT_W-1:0]    half [CHANNELS];
  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] apply;
  logic                pend_valid;
  logic [CH_W-1:0]     pend_ch;
  logic [CNT_W-1:0]    pend_half;
  logic                ch_ok;

  assign cfg_ready = ~pend_valid;
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

  // A pending value lands on its channel's terminal count, or at once if that channel is idle.
  always_comb begin
    tc    = '0;
    apply = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      tc[i]    = en[i] && (cnt[i] == half[i] - CNT_W'(1));
      apply[i] = pend_valid && (pend_ch == CH_W'(i)) && (!en[i] || tc[i]);
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i]  <= '0;
        half[i] <= DEF_HALF;
      end
      clk_out    <= '0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_half  <= '0;
`ifdef DIV_TICK_OUT_EN
      tick       <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!en[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
        end else if (tc[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
        end else begin
          cnt[i]     <= cnt[i] + CNT_W'(1);
        end
        if (apply[i]) begin
          half[i] <= pend_half;
        end
`ifdef DIV_TICK_OUT_EN
        tick[i] <= tc[i];
`endif
      end

      if (pend_valid) begin
        if (|apply) begin
          pend_valid <= 1'b0;
        end
      end else if (cfg_valid && ch_ok) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_half  <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
      end
    end
  end

endmodule
